// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the AXI-Stream packet checker.
// Error codes, FSM states, LFSR taps and last-word strobe mask.
package axis_chk_pkg;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_DATA  = 3'd1;
    localparam logic [2:0] ERR_STRB  = 3'd2;
    localparam logic [2:0] ERR_EARLY = 3'd3;
    localparam logic [2:0] ERR_MISS  = 3'd4;
    localparam logic [2:0] ERR_ID    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_DRAIN
    } chk_state_t;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction

    // Byte-length remainder to last-word strobe
    function automatic logic [3:0] exp_strb(input logic [1:0] rem);
        logic [3:0] m;
        m = 4'hF;
        unique case (rem)
            2'd1: m = 4'h1;
            2'd2: m = 4'h3;
            2'd3: m = 4'h7;
            default: m = 4'hF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/axis_bp_lfsr.sv
// Free-running 16-bit LFSR used as a pseudo-random
// throttle bit for tready / tvalid.
module axis_bp_lfsr
    import axis_chk_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    output logic bp_bit
);

    logic [15:0] lfsr;

    // Advance every cycle, independent of traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    assign bp_bit = lfsr[0];

endmodule

// File: rtl/axis_pkt_chk.sv
// AXI-Stream sink that checks packets against the generator
// pattern {seq, word} and reports counts and the first error.
module axis_pkt_chk
    import axis_chk_pkg::*;
#(
    parameter int          LEN_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             aclk_0,
    input  logic             aresetn_0,
    input  logic [31:0]      S_AXIS_0_tdata,
    input  logic [3:0]       S_AXIS_0_tstrb,
    input  logic             S_AXIS_0_tlast,
    input  logic             S_AXIS_0_tid,
    input  logic             S_AXIS_0_tdest,
    input  logic             S_AXIS_0_tvalid,
    output logic             S_AXIS_0_tready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_tid,
    input  logic             cfg_tdest,
    input  logic             cfg_bp_en,
    input  logic             clr_cnt,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      err_cnt,
    output logic             err_flag,
    output logic [2:0]       err_code
);

    logic             bp_bit;
    logic             acc;
    chk_state_t       state;
    logic [LEN_W-1:0] seq_q;
    logic [LEN_W-1:0] k_q;
    logic [LEN_W-1:0] w_q;
    logic [1:0]       rem_q;
    logic             tid_q;
    logic             tdest_q;
    logic             pkt_err_q;

    logic             idle;
    logic [LEN_W:0]   w_sum;
    logic [LEN_W-1:0] cfg_w;
    logic [LEN_W-1:0] cur_w;
    logic [1:0]       cur_rem;
    logic             cur_tid;
    logic             cur_tdest;
    logic             last_word;
    logic [3:0]       strb_x;
    logic [31:0]      data_x;
    logic             data_err;
    logic             id_err;
    logic             strb_err;
    logic             early;
    logic             miss;
    logic [2:0]       beat_code;
    logic             beat_err;
    logic             pkt_end;
    logic             pkt_bad;

    axis_bp_lfsr #(.SEED(LFSR_SEED)) u_bp (
        .clk    (aclk_0),
        .rst_n  (aresetn_0),
        .bp_bit (bp_bit)
    );

    assign S_AXIS_0_tready = ~cfg_bp_en | bp_bit;
    assign acc = S_AXIS_0_tvalid & S_AXIS_0_tready;

    // Word 0 is checked against live cfg, later words against the latch
    assign idle      = (state == ST_IDLE);
    assign w_sum     = {1'b0, cfg_len} + (LEN_W+1)'(3);
    assign cfg_w     = {1'b0, w_sum[LEN_W:2]};
    assign cur_w     = idle ? cfg_w        : w_q;
    assign cur_rem   = idle ? cfg_len[1:0] : rem_q;
    assign cur_tid   = idle ? cfg_tid      : tid_q;
    assign cur_tdest = idle ? cfg_tdest    : tdest_q;

    assign last_word = (k_q == cur_w - LEN_W'(1));
    assign strb_x    = last_word ? exp_strb(cur_rem) : 4'hF;
    assign data_x    = {16'(seq_q), 16'(k_q)};

    // Data compared only on bytes the expected strobe enables
    always_comb begin
        data_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (strb_x[i] &&
                S_AXIS_0_tdata[8*i +: 8] != data_x[8*i +: 8])
                data_err = 1'b1;
        end
    end

    assign id_err   = (S_AXIS_0_tid != cur_tid) |
                      (S_AXIS_0_tdest != cur_tdest);
    assign strb_err = (S_AXIS_0_tstrb != strb_x);
    assign early    = S_AXIS_0_tlast & ~last_word;
    assign miss     = ~S_AXIS_0_tlast & last_word;

    // Per-beat error code, highest priority first
    always_comb begin
        beat_code = ERR_NONE;
        if (id_err)        beat_code = ERR_ID;
        else if (strb_err) beat_code = ERR_STRB;
        else if (data_err) beat_code = ERR_DATA;
        else if (early)    beat_code = ERR_EARLY;
        else if (miss)     beat_code = ERR_MISS;
    end

    assign beat_err = acc & (state != ST_DRAIN) &
                      (beat_code != ERR_NONE);
    assign pkt_end  = acc & S_AXIS_0_tlast;
    assign pkt_bad  = pkt_err_q | beat_err;

    // Packet FSM: word tracking, config latch, sequence number
    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            state     <= ST_IDLE;
            seq_q     <= '0;
            k_q       <= '0;
            w_q       <= '0;
            rem_q     <= '0;
            tid_q     <= 1'b0;
            tdest_q   <= 1'b0;
            pkt_err_q <= 1'b0;
        end else if (acc) begin
            if (idle) begin
                w_q     <= cfg_w;
                rem_q   <= cfg_len[1:0];
                tid_q   <= cfg_tid;
                tdest_q <= cfg_tdest;
            end
            if (S_AXIS_0_tlast) begin
                state     <= ST_IDLE;
                k_q       <= '0;
                seq_q     <= seq_q + LEN_W'(1);
                pkt_err_q <= 1'b0;
            end else begin
                pkt_err_q <= pkt_bad;
                if (state != ST_DRAIN) begin
                    if (last_word) begin
                        state <= ST_DRAIN;
                    end else begin
                        state <= ST_BODY;
                        k_q   <= k_q + LEN_W'(1);
                    end
                end
            end
        end
    end

    // Status counters and sticky first-error; clear wins
    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
        end else if (clr_cnt) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (beat_err) begin
                err_flag <= 1'b1;
                if (err_code == ERR_NONE) err_code <= beat_code;
            end
            if (pkt_end) begin
                if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
                if (pkt_bad && err_cnt != '1)
                    err_cnt <= err_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_chk.sv
// Directed bench for axis_pkt_chk with a status scoreboard
// filled as packets are driven and drained as they complete.
module tb_axis_pkt_chk;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tlast = 1'b0;
    logic        tid = 1'b0;
    logic        tdest = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [15:0] cfg_len = 16'd8;
    logic        cfg_tid = 1'b0;
    logic        cfg_tdest = 1'b0;
    logic        cfg_bp_en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;
    logic        err_flag;
    logic [2:0]  err_code;

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    typedef struct {
        int unsigned pkt;
        int unsigned err;
        logic [2:0]  code;
    } exp_t;

    exp_t        sb[$];
    int unsigned m_pkt = 0;
    int unsigned m_err = 0;
    logic [2:0]  m_code = 3'd0;

    always #5 clk = ~clk;

    axis_pkt_chk dut (
        .aclk_0          (clk),
        .aresetn_0       (aresetn),
        .S_AXIS_0_tdata  (tdata),
        .S_AXIS_0_tstrb  (tstrb),
        .S_AXIS_0_tlast  (tlast),
        .S_AXIS_0_tid    (tid),
        .S_AXIS_0_tdest  (tdest),
        .S_AXIS_0_tvalid (tvalid),
        .S_AXIS_0_tready (tready),
        .cfg_len         (cfg_len),
        .cfg_tid         (cfg_tid),
        .cfg_tdest       (cfg_tdest),
        .cfg_bp_en       (cfg_bp_en),
        .clr_cnt         (clr_cnt),
        .pkt_cnt         (pkt_cnt),
        .err_cnt         (err_cnt),
        .err_flag        (err_flag),
        .err_code        (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of the status after a packet ends, queued for later compare
    task automatic expect_end(input bit bad, input logic [2:0] code,
                              input bit clr);
        exp_t e;
        if (clr) begin
            m_pkt = 0; m_err = 0; m_code = 3'd0;
        end else begin
            m_pkt++;
            if (bad) m_err++;
            if (m_code == 3'd0) m_code = code;
        end
        e.pkt = m_pkt; e.err = m_err; e.code = m_code;
        sb.push_back(e);
    endtask

    task automatic check_status(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pkt"}, pkt_cnt, e.pkt);
            chk({tag, "_err"}, err_cnt, e.err);
            chk({tag, "_code"}, {29'd0, err_code}, {29'd0, e.code});
            chk({tag, "_flag"}, {31'd0, err_flag},
                {31'd0, e.code != 3'd0});
        end
    endtask

    // Present one beat and hold it until accepted, bounded
    task automatic beat(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
        logic rdy;
        bit   done;
        done = 0;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            rdy = tready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $error("FAIL beat_timeout: observed no tready expected accept");
        end
    endtask

    task automatic send_pkt(input int words, input int seq);
        for (int k = 0; k < words; k++)
            beat({16'(seq), 16'(k)}, 4'hF, k == words - 1);
    endtask

    task automatic idle_cyc();
        tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk);
        #1 aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        m_pkt = 0; m_err = 0; m_code = 3'd0;
        sb.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;

        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_flag", {31'd0, err_flag}, 0);
        chk("rst_code", {29'd0, err_code}, 0);
        chk("rst_tready", {31'd0, tready}, 1);

        // 8-byte good packet
        cfg_len = 16'd8;
        beat(32'h0000_0000, 4'hF, 1'b0);
        expect_end(0, 3'd0, 0);
        beat(32'h0000_0001, 4'hF, 1'b1);
        check_status("len8");
        idle_cyc();

        // 5-byte packets: partial strobe good, then wrong strobe
        do_reset();
        cfg_len = 16'd5;
        beat(32'h0000_0000, 4'hF, 1'b0);
        expect_end(0, 3'd0, 0);
        beat(32'hDEAD_BE01, 4'h1, 1'b1);
        check_status("len5_good");
        beat(32'h0001_0000, 4'hF, 1'b0);
        expect_end(1, 3'd2, 0);
        beat(32'h0001_0001, 4'h3, 1'b1);
        check_status("len5_strb");
        idle_cyc();

        // Data error in packet 1, packet 2 still expects seq 2
        do_reset();
        cfg_len = 16'd8;
        expect_end(0, 3'd0, 0);
        send_pkt(2, 0);
        check_status("seq0");
        beat(32'h0001_0000, 4'hF, 1'b0);
        expect_end(1, 3'd1, 0);
        beat(32'h0001_0005, 4'hF, 1'b1);
        check_status("data_err");
        expect_end(0, 3'd0, 0);
        send_pkt(2, 2);
        check_status("seq2");
        idle_cyc();

        // Early tlast on a 12-byte packet
        do_reset();
        cfg_len = 16'd12;
        beat(32'h0000_0000, 4'hF, 1'b0);
        expect_end(1, 3'd3, 0);
        beat(32'h0000_0001, 4'hF, 1'b1);
        check_status("early");

        // Clear, then missing tlast on a 4-byte packet drains to tlast
        clr_cnt = 1'b1;
        idle_cyc();
        clr_cnt = 1'b0;
        m_pkt = 0; m_err = 0; m_code = 3'd0;
        chk("clr_pkt", pkt_cnt, 0);
        chk("clr_code", {29'd0, err_code}, 0);
        cfg_len = 16'd4;
        beat(32'h0001_0000, 4'hF, 1'b0);
        beat(32'h1234_5678, 4'hF, 1'b0);
        expect_end(1, 3'd4, 0);
        beat(32'h9ABC_DEF0, 4'hF, 1'b1);
        check_status("miss");
        expect_end(0, 3'd0, 0);
        send_pkt(1, 2);
        check_status("after_drain");
        idle_cyc();

        // tid error outranks strobe and data on the same beat
        do_reset();
        cfg_len = 16'd4;
        tid = 1'b1;
        expect_end(1, 3'd5, 0);
        beat(32'hFFFF_FFFF, 4'h3, 1'b1);
        check_status("prio");
        tid = 1'b0;
        idle_cyc();

        // Random backpressure, 100 back-to-back 64-byte packets
        do_reset();
        cfg_bp_en = 1'b1;
        cfg_len = 16'd64;
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            expect_end(0, 3'd0, 0);
            send_pkt(16, n);
            check_status("bp");
        end
        chk("bp_stalls", {31'd0, stalls > 0}, 1);
        chk("bp_total", pkt_cnt, 100);
        idle_cyc();
        cfg_bp_en = 1'b0;

        // Clear coincident with tlast, then mid-packet cfg change
        do_reset();
        cfg_len = 16'd8;
        for (int n = 0; n < 3; n++) begin
            expect_end(0, 3'd0, 0);
            send_pkt(2, n);
            check_status("pre_clr");
        end
        beat(32'h0003_0000, 4'hF, 1'b0);
        expect_end(0, 3'd0, 1);
        clr_cnt = 1'b1;
        beat(32'h0003_0001, 4'hF, 1'b1);
        clr_cnt = 1'b0;
        check_status("clr_tlast");
        beat(32'h0004_0000, 4'hF, 1'b0);
        cfg_len = 16'd4;
        expect_end(0, 3'd0, 0);
        beat(32'h0004_0001, 4'hF, 1'b1);
        check_status("seq4");
        idle_cyc();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
